// File: rtl/calc_op_player.sv
// calc_op_player: plays an accepted ALU opcode as a timed {btnl,btnc,btnr} pattern.
// Optional macro CALC_OP_PLAYER_LOOPBACK_EN adds a sticky loop_err from re-decoding the driven buttons.
module calc_op_player #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       btnu,
  input  logic       op_valid,
  input  logic [3:0] alu_op,
  output logic       op_ready,
  output logic       btnl,
  output logic       btnc,
  output logic       btnr,
  output logic       btn_valid,
  output logic       done,
  output logic       err
`ifdef CALC_OP_PLAYER_LOOPBACK_EN
  ,
  output logic       loop_err
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP, ERR} state_t;

  // Counter loads "cycles - 1" on state entry and leaves the state when it reaches zero.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  // Returns {legal, l, c, r}.
  function automatic logic [3:0] map_op(input logic [3:0] op);
    case (op)
      4'd0:    map_op = 4'b1_010;
      4'd1:    map_op = 4'b1_011;
      4'd2:    map_op = 4'b1_000;
      4'd6:    map_op = 4'b1_001;
      4'd7:    map_op = 4'b1_101;
      4'd9:    map_op = 4'b1_110;
      4'd10:   map_op = 4'b1_111;
      4'd13:   map_op = 4'b1_100;
      default: map_op = 4'b0_000;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] btn_d;
  logic       btn_valid_d;
  logic       done_d;
  logic       err_d;
  logic [3:0] map_w;
  logic       accept;

  assign map_w    = map_op(alu_op);
  assign op_ready = (state_q == IDLE);
  assign accept   = op_valid && op_ready;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    btn_d       = {btnl, btnc, btnr};
    btn_valid_d = btn_valid;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (map_w[3]) begin
            state_d     = HOLD;
            cnt_d       = HOLD_LOAD;
            btn_d       = map_w[2:0];
            btn_valid_d = 1'b1;
          end else begin
            state_d = ERR;
            cnt_d   = 8'd0;
            err_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          btn_d       = 3'b000;
          btn_valid_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ERR: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      state_q            <= IDLE;
      cnt_q              <= 8'd0;
      {btnl, btnc, btnr} <= 3'b000;
      btn_valid          <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      {btnl, btnc, btnr} <= btn_d;
      btn_valid          <= btn_valid_d;
      done               <= done_d;
      err                <= err_d;
    end
  end

`ifdef CALC_OP_PLAYER_LOOPBACK_EN
  logic [3:0] op_q;
  logic [3:0] dec;

  // Inverse of the opcode map, applied to the buttons actually driven.
  always_comb begin
    dec[0] = (~btnr & btnl) | ((btnl ^ btnc) & btnr);
    dec[1] = (btnl & btnr) | (~btnl & ~btnc);
    dec[2] = (btnl | btnr) & ~btnc;
    dec[3] = btnl & ~(btnr & ~btnc);
  end

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      op_q     <= 4'd0;
      loop_err <= 1'b0;
    end else begin
      if (accept && map_w[3]) op_q <= alu_op;
      if ((state_q == HOLD) && btn_valid && (dec != op_q)) loop_err <= 1'b1;
    end
  end
`endif

endmodule
